// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Purpose:
//   This block answers the cache's line-granular physical-memory port. It turns
//   each LINE_W-bit line read or write into a burst of BEATS transfers of
//   BURST_W bits each on the main-memory port. It sequences the beats,
//   assembles read lines, splits write lines into beats, and raises a
//   one-cycle line response when the burst is complete.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   address_i    line address from the cache (any byte within the line)
//   read_i       line read request, held by the cache until resp_o
//   write_i      line write request, held by the cache until resp_o
//   line_i       write line from the cache, valid while write_i is high
//   line_o       assembled read line; the cache loads it in the resp_o cycle
//   resp_o       one-cycle pulse that marks the end of the line transfer
//   address_o    line-aligned burst address, held until the next acceptance
//   read_o       burst read request to memory
//   write_o      burst write request to memory
//   burst_o      current write beat, valid from the first write_o cycle
//   burst_i      read beat data from memory, valid when resp_i is high
//   resp_i       per-beat handshake from memory
//
// Handshake semantics:
//   Cache side: the level on read_i/write_i is a request. It is sampled only
//   in IDLE, and the cache holds it until it sees resp_o. resp_o lasts exactly
//   one cycle, in the DONE state. Because requests are ignored outside IDLE, a
//   request level still high during DONE is never taken as a new transaction.
//   Memory side: read_o/write_o stay high for the whole burst. Every cycle with
//   resp_i=1 moves one beat. Cycles with resp_i=0 are wait states and change
//   nothing. For reads, burst_i is captured on each resp_i cycle. For writes,
//   burst_o already holds the beat memory is accepting, and the next beat
//   appears in the cycle after resp_i. resp_i outside RD/WR is ignored.
//
// All outputs are registered. BEATS = LINE_W/BURST_W must be a power of two
// and at least 2.
// -----------------------------------------------------------------------------
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,

  // cache-facing line port
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,

  // memory-facing burst port
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  // Byte-offset bits inside one line; these are cleared in the burst address.
  localparam int OFS   = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [LINE_W-1:0]   wr_buf;

  logic [CNT_W-1:0]    cnt_nxt;
  logic                last_beat;
  logic [ADDR_W-1:0]   line_addr;
  logic [BURST_W-1:0]  next_beat;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_nxt   = cnt + CNT_W'(1);
    last_beat = (cnt == LAST_BEAT);
    line_addr = {address_i[ADDR_W-1:OFS], {OFS{1'b0}}};
  end

  // Selects the write beat that follows the current one. A mux with constant
  // indices keeps the part-selects static.
  always_comb begin
    next_beat = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt_nxt == CNT_W'(b)) begin
        next_beat = wr_buf[b*BURST_W +: BURST_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and all registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_buf    <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
      burst_o   <= '0;
      line_o    <= '0;
    end else begin
      // resp_o is raised only on the transition into DONE, so it lasts
      // exactly the single DONE cycle.
      resp_o <= 1'b0;

      case (state)
        IDLE: begin
          // A write wins over a read. Both high together is illegal but
          // still handled deterministically.
          if (write_i) begin
            state     <= WR;
            cnt       <= '0;
            address_o <= line_addr;
            wr_buf    <= line_i;
            write_o   <= 1'b1;
            // Beat 0 is ready in the same cycle write_o first goes high.
            burst_o   <= line_i[BURST_W-1:0];
          end else if (read_i) begin
            state     <= RD;
            cnt       <= '0;
            address_o <= line_addr;
            read_o    <= 1'b1;
          end
        end

        RD: begin
          if (resp_i) begin
            // line_o is written in place. It keeps the previous line until
            // the first beat of this read lands.
            for (int b = 0; b < BEATS; b++) begin
              if (cnt == CNT_W'(b)) begin
                line_o[b*BURST_W +: BURST_W] <= burst_i;
              end
            end
            if (last_beat) begin
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end

        WR: begin
          if (resp_i) begin
            if (last_beat) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end else begin
              cnt     <= cnt_nxt;
              burst_o <= next_beat;
            end
          end
        end

        DONE: begin
          // Request levels are still high here. They are deliberately not
          // sampled; the next acceptance can happen in the following IDLE.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
